// File: rtl/pixel_map.sv
// rtl/pixel_map.sv - display raster walker producing mirrored/zoomed/panned SRAM source addresses
module pixel_map #(
  parameter int DISPLAY_WIDTH  = 800,
  parameter int DISPLAY_HEIGHT = 480,
  parameter int INPUT_WIDTH    = 800,
  parameter int INPUT_HEIGHT   = 480
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        iREAD,
  input  logic [17:0] iSW,
  output logic [19:0] oADDRESS,
  output logic        oREADY_N
);

  localparam int XW = $clog2(DISPLAY_WIDTH);
  localparam int YW = $clog2(DISPLAY_HEIGHT);
  localparam logic signed [11:0] CX = 12'(DISPLAY_WIDTH / 2);
  localparam logic signed [11:0] CY = 12'(DISPLAY_HEIGHT / 2);
  localparam logic signed [11:0] IW = 12'(INPUT_WIDTH);
  localparam logic signed [11:0] IH = 12'(INPUT_HEIGHT);

  typedef enum logic [1:0] {S_INIT, S_READY, S_LOAD} state_t;

  state_t            state_q;
  logic [XW-1:0]     dx_q, dx_d;
  logic [YW-1:0]     dy_q, dy_d;
  logic [15:0]       sw_q;
  logic [15:0]       sw_sel;
  logic              frame_wrap;
  logic signed [11:0] mx, my, zx, zy, hx8, hy8, sx, sy;
  logic              valid;
  logic [18:0]       lin;
  logic [19:0]       addr_d;
  logic              unused_sw;

  assign unused_sw = ^iSW[17:16];

  function automatic logic signed [11:0] zoom(input logic signed [11:0] m,
                                              input logic signed [11:0] c,
                                              input logic [1:0]         z);
    logic signed [11:0] d;
    d = m - c;
    case (z)
      2'b00:   zoom = m;
      2'b01:   zoom = c + (d >>> 1);
      2'b10:   zoom = c + (d >>> 2);
      default: zoom = c + (d <<< 1);
    endcase
  endfunction

  always_comb begin
    dx_d = dx_q + XW'(1);
    dy_d = dy_q;
    if (dx_q == XW'(DISPLAY_WIDTH - 1)) begin
      dx_d = '0;
      dy_d = (dy_q == YW'(DISPLAY_HEIGHT - 1)) ? '0 : dy_q + YW'(1);
    end
  end

  assign frame_wrap = (dx_d == '0) && (dy_d == '0);

  // The very first address after reset uses iSW directly, since it is captured on that same edge.
  always_comb begin
    sw_sel = (state_q == S_INIT) ? iSW[15:0] : sw_q;
    mx     = sw_sel[0] ? 12'(DISPLAY_WIDTH - 1 - int'(dx_q)) : 12'(dx_q);
    my     = sw_sel[1] ? 12'(DISPLAY_HEIGHT - 1 - int'(dy_q)) : 12'(dy_q);
    zx     = zoom(mx, CX, sw_sel[3:2]);
    zy     = zoom(my, CY, sw_sel[3:2]);
    hx8    = {{3{sw_sel[9]}}, sw_sel[9:4], 3'b000};
    hy8    = {{3{sw_sel[15]}}, sw_sel[15:10], 3'b000};
    sx     = zx - hx8;
    sy     = zy - hy8;
    valid  = (sx >= 12'sd0) && (sx < IW) && (sy >= 12'sd0) && (sy < IH);
    lin    = 19'(sy[10:0]) * 19'(INPUT_WIDTH) + 19'(sx[10:0]);
    addr_d = valid ? {1'b1, lin} : 20'h7FFFF;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_INIT;
      dx_q     <= '0;
      dy_q     <= '0;
      sw_q     <= '0;
      oADDRESS <= '0;
      oREADY_N <= 1'b1;
    end else begin
      case (state_q)
        S_INIT: begin
          sw_q     <= iSW[15:0];
          oADDRESS <= addr_d;
          oREADY_N <= 1'b0;
          state_q  <= S_READY;
        end
        S_READY: begin
          if (iREAD) begin
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            if (frame_wrap) sw_q <= iSW[15:0];
            oREADY_N <= 1'b1;
            state_q  <= S_LOAD;
          end
        end
        S_LOAD: begin
          oADDRESS <= addr_d;
          oREADY_N <= 1'b0;
          state_q  <= S_READY;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_map.sv
// tb/tb_pixel_map.sv - directed-vector bench for pixel_map (full-size and small-raster instances)
module tb_pixel_map;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        iREAD = 1'b0, iREAD2 = 1'b0;
  logic [17:0] iSW = '0, iSW2 = '0;
  logic [19:0] oADDRESS, oADDRESS2;
  logic        oREADY_N, oREADY_N2;

  int n_checks = 0;
  int n_errors = 0;
  logic [19:0] a;

  always #5 CLK = ~CLK;

  pixel_map u_dut (
    .CLK(CLK), .RESET(RESET), .iREAD(iREAD), .iSW(iSW),
    .oADDRESS(oADDRESS), .oREADY_N(oREADY_N)
  );

  // 8x4 raster so a whole frame and its wrap fit in a short run
  pixel_map #(.DISPLAY_WIDTH(8), .DISPLAY_HEIGHT(4), .INPUT_WIDTH(8), .INPUT_HEIGHT(4)) u_small (
    .CLK(CLK), .RESET(RESET), .iREAD(iREAD2), .iSW(iSW2),
    .oADDRESS(oADDRESS2), .oREADY_N(oREADY_N2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rdy_n(input int which);
    return (which == 0) ? oREADY_N : oREADY_N2;
  endfunction

  task automatic do_reset(input logic [17:0] sw, input logic [17:0] sw2);
    @(negedge CLK);
    RESET = 1'b1; iREAD = 1'b0; iREAD2 = 1'b0; iSW = sw; iSW2 = sw2;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic read_px(input int which, output logic [19:0] addr);
    int n;
    n = 0;
    while (rdy_n(which) !== 1'b0 && n < 16) begin
      @(posedge CLK); #1;
      n++;
    end
    if (rdy_n(which) !== 1'b0) check("ready_timeout", 32'(rdy_n(which)), 32'd0);
    addr = (which == 0) ? oADDRESS : oADDRESS2;
    if (which == 0) iREAD = 1'b1; else iREAD2 = 1'b1;
    @(posedge CLK); #1;
    iREAD = 1'b0; iREAD2 = 1'b0;
  endtask

  task automatic first_addr(input string tag, input logic [17:0] sw, input logic [19:0] exp);
    do_reset(sw, '0);
    check({tag, "_rdy"}, 32'(oREADY_N), 32'd0);
    check(tag, 32'(oADDRESS), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // reset state and plain raster
    repeat (3) @(posedge CLK);
    #1;
    check("rst_rdy", 32'(oREADY_N), 32'd1);
    check("rst_addr", 32'(oADDRESS), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK); #1;
    check("first_rdy", 32'(oREADY_N), 32'd0);
    check("first_addr", 32'(oADDRESS), 32'h80000);
    read_px(0, a); check("read0", 32'(a), 32'h80000);
    read_px(0, a); check("read1", 32'(a), 32'h80001);
    read_px(0, a); check("read2", 32'(a), 32'h80002);
    repeat (797) read_px(0, a);
    read_px(0, a); check("read800", 32'(a), 32'h80320);
    repeat (122) read_px(0, a);
    @(posedge CLK); #1;
    check("px_123_1", 32'(oADDRESS), 32'h8039B);

    // asynchronous reset mid-frame
    #2 RESET = 1'b1;
    #1;
    check("async_rdy", 32'(oREADY_N), 32'd1);
    check("async_addr", 32'(oADDRESS), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK); #1;
    check("after_async_rdy", 32'(oREADY_N), 32'd0);
    check("after_async_addr", 32'(oADDRESS), 32'h80000);

    // mirror
    first_addr("mirror_x", 18'h00001, 20'h8031F);
    first_addr("mirror_y", 18'h00002, 20'hDD8E0);
    first_addr("mirror_xy", 18'h00003, 20'hDDBFF);

    // zoom; dx=1 under 2x checks flooring of the arithmetic shift
    first_addr("zoom2", 18'h00004, 20'h977C8);
    read_px(0, a);
    read_px(0, a); check("zoom2_dx1", 32'(a), 32'h977C8);
    read_px(0, a); check("zoom2_dx2", 32'(a), 32'h977C9);
    first_addr("zoom4", 18'h00008, 20'hA33AC);
    first_addr("zoom_half", 18'h0000C, 20'h7FFFF);
    first_addr("zoom_half_pan", 18'h0800C, 20'h7FFFF);
    repeat (199) read_px(0, a);
    read_px(0, a); check("zoom_half_dx199", 32'(a), 32'h7FFFF);
    read_px(0, a); check("zoom_half_dx200", 32'(a), 32'h83200);
    read_px(0, a); check("zoom_half_dx201", 32'(a), 32'h83202);

    // pan
    do_reset(18'h00010, '0);
    for (int i = 0; i < 8; i++) begin
      read_px(0, a); check("pan_x_left", 32'(a), 32'h7FFFF);
    end
    read_px(0, a); check("pan_x_dx8", 32'(a), 32'h80000);
    first_addr("pan_y_neg", 18'h0FC00, 20'h81900);

    // iREAD held high: one pixel per two cycles
    do_reset('0, '0);
    iREAD = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge CLK); #1;
      check("held_rdy", 32'(oREADY_N), (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i % 2 == 0) check("held_addr", 32'(oADDRESS), 32'h80000 + 32'(i / 2));
    end
    // second edge of this pulse lands while oREADY_N=1 and must be ignored
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    iREAD = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    check("ignored_rdy", 32'(oREADY_N), 32'd0);
    check("ignored_addr", 32'(oADDRESS), 32'h80003);
    read_px(0, a);
    read_px(0, a); check("ignored_next", 32'(a), 32'h80004);

    // small raster: full frame, mid-frame switch change, wrap recapture
    do_reset('0, '0);
    for (int k = 0; k < 32; k++) begin
      read_px(1, a);
      check("small_frame", 32'(a), 32'h80000 + 32'(k));
      if (k == 2) iSW2 = 18'h00001;
    end
    read_px(1, a); check("small_wrap_mirror0", 32'(a), 32'h80007);
    read_px(1, a); check("small_wrap_mirror1", 32'(a), 32'h80006);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
